// File: rtl/queen_seq_ctrl.sv
// Backtracking N-queen sequencer: walks rows/columns, hands each candidate to an
// external conflict checker over req/ack, then streams the first solution one-hot.
`timescale 1ns/10ps
module queen_seq_ctrl #(
  parameter int N  = 8,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          chk_req,
  output logic [CW-1:0] chk_row,
  output logic [CW-1:0] chk_col,
  input  logic          chk_ack,
  input  logic          chk_safe,
  input  logic [CW-1:0] brd_rd_row,
  output logic [CW-1:0] brd_rd_col,
  output logic          busy,
  output logic          out_valid,
  output logic [CW-1:0] out_row,
  output logic [N-1:0]  out,
  output logic          done,
  output logic          no_answer
);

  typedef enum logic [2:0] {IDLE, CHECK, GAP, BACK, EMIT, FIN} state_t;

  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [N-1:0]  ONE  = N'(1);

  state_t        state, state_nx;
  logic [CW-1:0] r, r_nx;
  logic [CW-1:0] c, c_nx;
  logic [CW-1:0] k, k_nx;
  logic          na_q, na_nx;
  logic          wr_en;
  logic [CW-1:0] r_dec;
  logic [CW-1:0] prev_col;
  logic [CW-1:0] board [N];

  assign r_dec    = r - 1'b1;
  assign prev_col = board[r_dec];

  // Rows beyond N-1 are unreachable addresses when N is not a power of two.
  assign brd_rd_col = (int'(brd_rd_row) < N) ? board[brd_rd_row] : '0;

  always_comb begin
    state_nx = state;
    r_nx     = r;
    c_nx     = c;
    k_nx     = k;
    na_nx    = na_q;
    wr_en    = 1'b0;
    case (state)
      IDLE, FIN: begin
        if (start) begin
          r_nx     = '0;
          c_nx     = '0;
          k_nx     = '0;
          na_nx    = 1'b0;
          state_nx = CHECK;
        end
      end
      CHECK: begin
        if (chk_ack) begin
          if (chk_safe) begin
            wr_en = 1'b1;
            if (r == LAST) begin
              k_nx     = '0;
              state_nx = EMIT;
            end else begin
              r_nx     = r + 1'b1;
              c_nx     = '0;
              state_nx = GAP;
            end
          end else if (c < LAST) begin
            c_nx     = c + 1'b1;
            state_nx = GAP;
          end else begin
            state_nx = BACK;
          end
        end
      end
      GAP: state_nx = CHECK;
      BACK: begin
        if (r == '0) begin
          na_nx    = 1'b1;
          state_nx = FIN;
        end else begin
          r_nx = r_dec;
          // An exhausted parent row keeps us in BACK to pop one more row next cycle.
          if (prev_col < LAST) begin
            c_nx     = prev_col + 1'b1;
            state_nx = GAP;
          end
        end
      end
      EMIT: begin
        if (k == LAST) begin
          na_nx    = 1'b0;
          state_nx = FIN;
        end else begin
          k_nx = k + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      r     <= '0;
      c     <= '0;
      k     <= '0;
      na_q  <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        board[i] <= '0;
      end
    end else begin
      state <= state_nx;
      r     <= r_nx;
      c     <= c_nx;
      k     <= k_nx;
      na_q  <= na_nx;
      if (wr_en) begin
        board[r] <= c;
      end
    end
  end

  always_comb begin
    chk_req   = (state == CHECK);
    chk_row   = '0;
    chk_col   = '0;
    busy      = (state == CHECK) || (state == GAP) || (state == BACK) || (state == EMIT);
    out_valid = (state == EMIT);
    out_row   = '0;
    out       = '0;
    done      = (state == FIN);
    no_answer = (state == FIN) && na_q;
    if (state == CHECK) begin
      chk_row = r;
      chk_col = c;
    end
    if (state == EMIT) begin
      out_row = k;
      out     = ONE << board[k];
    end
  end

endmodule

// File: tb/tb_queen_seq_ctrl.sv
// Bench for queen_seq_ctrl: N=8/4/3 instances, behavioural checker with
// randomized ack latency, and a backtracking reference model.
`timescale 1ns/10ps
module tb_queen_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_a [3];
  logic ack_a   [3] = '{default: 1'b0};
  logic safe_a  [3] = '{default: 1'b0};
  int   rdrow_a [3] = '{default: 0};

  logic       req8, busy8, ov8, done8, na8;
  logic [2:0] row8, col8, rdcol8, orow8;
  logic [7:0] out8;
  logic       req4, busy4, ov4, done4, na4;
  logic [1:0] row4, col4, rdcol4, orow4;
  logic [3:0] out4;
  logic       req3, busy3, ov3, done3, na3;
  logic [1:0] row3, col3, rdcol3, orow3;
  logic [2:0] out3;

  queen_seq_ctrl #(.N(8), .CW(3)) u_q8 (
    .clk(clk), .rst(rst), .start(start_a[0]), .chk_req(req8), .chk_row(row8),
    .chk_col(col8), .chk_ack(ack_a[0]), .chk_safe(safe_a[0]), .brd_rd_row(rdrow_a[0][2:0]),
    .brd_rd_col(rdcol8), .busy(busy8), .out_valid(ov8), .out_row(orow8), .out(out8),
    .done(done8), .no_answer(na8));

  queen_seq_ctrl #(.N(4), .CW(2)) u_q4 (
    .clk(clk), .rst(rst), .start(start_a[1]), .chk_req(req4), .chk_row(row4),
    .chk_col(col4), .chk_ack(ack_a[1]), .chk_safe(safe_a[1]), .brd_rd_row(rdrow_a[1][1:0]),
    .brd_rd_col(rdcol4), .busy(busy4), .out_valid(ov4), .out_row(orow4), .out(out4),
    .done(done4), .no_answer(na4));

  queen_seq_ctrl #(.N(3), .CW(2)) u_q3 (
    .clk(clk), .rst(rst), .start(start_a[2]), .chk_req(req3), .chk_row(row3),
    .chk_col(col3), .chk_ack(ack_a[2]), .chk_safe(safe_a[2]), .brd_rd_row(rdrow_a[2][1:0]),
    .brd_rd_col(rdcol3), .busy(busy3), .out_valid(ov3), .out_row(orow3), .out(out3),
    .done(done3), .no_answer(na3));

  int req_a [3], row_a [3], col_a [3], rdcol_a [3], busy_a [3];
  int ov_a [3], orow_a [3], out_a [3], done_a [3], na_a [3];

  assign req_a[0] = int'(req8);   assign req_a[1] = int'(req4);   assign req_a[2] = int'(req3);
  assign row_a[0] = int'(row8);   assign row_a[1] = int'(row4);   assign row_a[2] = int'(row3);
  assign col_a[0] = int'(col8);   assign col_a[1] = int'(col4);   assign col_a[2] = int'(col3);
  assign rdcol_a[0] = int'(rdcol8); assign rdcol_a[1] = int'(rdcol4); assign rdcol_a[2] = int'(rdcol3);
  assign busy_a[0] = int'(busy8); assign busy_a[1] = int'(busy4); assign busy_a[2] = int'(busy3);
  assign ov_a[0] = int'(ov8);     assign ov_a[1] = int'(ov4);     assign ov_a[2] = int'(ov3);
  assign orow_a[0] = int'(orow8); assign orow_a[1] = int'(orow4); assign orow_a[2] = int'(orow3);
  assign out_a[0] = int'(out8);   assign out_a[1] = int'(out4);   assign out_a[2] = int'(out3);
  assign done_a[0] = int'(done8); assign done_a[1] = int'(done4); assign done_a[2] = int'(done3);
  assign na_a[0] = int'(na8);     assign na_a[1] = int'(na4);     assign na_a[2] = int'(na3);

  int nn [3] = '{8, 4, 3};
  int latmode [3];
  int cnt [3], lat [3], chk_cnt [3], em_n [3];
  int prev_req [3], prev_ack [3], prev_row [3], prev_col [3], prev_busy [3];
  int mb [3][16];
  int em_row [3][16];
  int em_out [3][16];
  bit rb_en [3];

  int ref_sol [16];
  int ref_checks;
  bit ref_found;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int               id;
    int               lat;      // -1: random 0..3 cycles per request
    bit               noise;    // pulse start while busy
    bit               exp_na;
    logic [7:0][15:0] exp_out;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Plain lexicographic backtracking: try column c in row r, descend on success,
  // otherwise advance c; an exhausted row pops back to the previous one.
  task automatic ref_solve(input int n);
    int col [16];
    int r;
    int c;
    r = 0;
    c = 0;
    ref_checks = 0;
    ref_found = 1'b0;
    for (int i = 0; i < 16; i++) col[i] = 0;
    while (1) begin
      if (c < n) begin
        bit ok;
        ok = 1'b1;
        ref_checks++;
        for (int i = 0; i < r; i++)
          if (col[i] == c || col[i] - c == r - i || c - col[i] == r - i) ok = 1'b0;
        if (ok) begin
          col[r] = c;
          if (r == n - 1) begin
            ref_found = 1'b1;
            break;
          end
          r++;
          c = 0;
        end else begin
          c++;
        end
      end else begin
        if (r == 0) break;
        r--;
        c = col[r] + 1;
      end
    end
    for (int i = 0; i < 16; i++) ref_sol[i] = col[i];
  endtask

  function automatic bit model_safe(input int id, input int row, input int col);
    for (int i = 0; i < row; i++) begin
      int d;
      d = mb[id][i] - col;
      if (d == 0 || d == row - i || -d == row - i) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Behavioural conflict checker plus output monitor for all three instances.
  always @(negedge clk) begin
    for (int id = 0; id < 3; id++) begin
      if (prev_busy[id] == 0 && busy_a[id] != 0) begin
        chk_cnt[id] = 0;
        em_n[id] = 0;
      end
      prev_busy[id] = busy_a[id];
      if (ov_a[id] != 0) begin
        if (em_n[id] < 16) begin
          em_row[id][em_n[id]] = orow_a[id];
          em_out[id][em_n[id]] = out_a[id];
        end
        em_n[id]++;
      end else begin
        check("idle_out", out_a[id], 0);
        check("idle_out_row", orow_a[id], 0);
      end
      if (req_a[id] != 0) begin
        if (prev_ack[id] != 0) begin
          check("req_gap", req_a[id], 0);
        end else if (prev_req[id] != 0) begin
          check("hold_row", row_a[id], prev_row[id]);
          check("hold_col", col_a[id], prev_col[id]);
        end
        if (prev_req[id] == 0 || prev_ack[id] != 0) begin
          chk_cnt[id]++;
          cnt[id] = 0;
          lat[id] = (latmode[id] < 0) ? int'($urandom_range(3, 0)) : latmode[id];
        end
        if (cnt[id] == lat[id]) begin
          ack_a[id] = 1'b1;
          safe_a[id] = model_safe(id, row_a[id], col_a[id]);
          if (safe_a[id]) mb[id][row_a[id]] = col_a[id];
        end else begin
          ack_a[id] = 1'b0;
          safe_a[id] = 1'($urandom_range(1, 0));
        end
        prev_ack[id] = int'(ack_a[id]);
        cnt[id]++;
      end else begin
        // stray acks outside CHECK must be ignored
        ack_a[id] = ($urandom_range(7, 0) == 0);
        safe_a[id] = 1'($urandom_range(1, 0));
        prev_ack[id] = 0;
      end
      prev_req[id] = req_a[id];
      prev_row[id] = row_a[id];
      prev_col[id] = col_a[id];
    end
  end

  // Board read port: prior placements during CHECK, full solution in FIN.
  always @(negedge clk) begin
    #1;
    for (int id = 0; id < 3; id++) begin
      if (req_a[id] != 0) begin
        for (int i = 0; i < row_a[id]; i++) begin
          rdrow_a[id] = i;
          #0.2;
          check("board_rd", rdcol_a[id], mb[id][i]);
        end
      end else if (done_a[id] != 0 && rb_en[id]) begin
        for (int i = 0; i < nn[id]; i++) begin
          rdrow_a[id] = i;
          #0.2;
          check("fin_board", rdcol_a[id], ref_sol[i]);
        end
      end
    end
  end

  task automatic run_solve(input int id, input bit noise);
    int cyc;
    @(negedge clk);
    start_a[id] = 1'b1;
    @(negedge clk);
    start_a[id] = 1'b0;
    check("busy_after_start", busy_a[id], 1);
    check("done_clear", done_a[id], 0);
    check("na_clear", na_a[id], 0);
    cyc = 0;
    while (done_a[id] == 0 && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      start_a[id] = noise && (cyc == 40 || cyc == 200);
    end
    start_a[id] = 1'b0;
    if (done_a[id] == 0) check("solve_timeout", done_a[id], 1);
  endtask

  task automatic apply_vec(input int j);
    vec_t v;
    int id;
    int n;
    int ne;
    v = tbl[j];
    id = v.id;
    n = nn[id];
    latmode[id] = v.lat;
    ref_solve(n);
    run_solve(id, v.noise);
    check("fin_done", done_a[id], 1);
    check("fin_busy", busy_a[id], 0);
    check("fin_no_answer", na_a[id], int'(v.exp_na));
    check("ref_no_answer", na_a[id], int'(!ref_found));
    check("emit_count", em_n[id], v.exp_na ? 0 : n);
    check("check_count", chk_cnt[id], ref_checks);
    if (id == 0) check("check_count_876", chk_cnt[id], 876);
    ne = (em_n[id] < 16) ? em_n[id] : 16;
    for (int kk = 0; kk < ne && kk < n; kk++) begin
      check("emit_row", em_row[id][kk], kk);
      check("emit_out", em_out[id][kk], int'(v.exp_out[kk]));
      check("emit_out_ref", em_out[id][kk], 1 << ref_sol[kk]);
    end
    if (!v.exp_na) begin
      rb_en[id] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rb_en[id] = 1'b0;
    end
  endtask

  initial begin
    tbl[0].id = 0; tbl[0].lat = 0;  tbl[0].noise = 0; tbl[0].exp_na = 0;
    tbl[0].exp_out = {16'h08, 16'h02, 16'h40, 16'h04, 16'h20, 16'h80, 16'h10, 16'h01};
    tbl[1].id = 1; tbl[1].lat = 5;  tbl[1].noise = 0; tbl[1].exp_na = 0;
    tbl[1].exp_out = {16'h0, 16'h0, 16'h0, 16'h0, 16'h4, 16'h1, 16'h8, 16'h2};
    tbl[2].id = 2; tbl[2].lat = 0;  tbl[2].noise = 0; tbl[2].exp_na = 1;
    tbl[2].exp_out = '0;
    tbl[3] = tbl[0]; tbl[3].lat = -1; tbl[3].noise = 1;
    tbl[4] = tbl[1]; tbl[4].lat = -1;
    tbl[5] = tbl[2]; tbl[5].lat = -1;

    rst = 1'b1;
    for (int id = 0; id < 3; id++) begin
      start_a[id] = 1'b0;
      latmode[id] = 0;
      rb_en[id] = 1'b0;
    end
    #3;
    for (int id = 0; id < 3; id++) begin
      check("rst_req", req_a[id], 0);
      check("rst_busy", busy_a[id], 0);
      check("rst_valid", ov_a[id], 0);
      check("rst_out", out_a[id], 0);
      check("rst_out_row", orow_a[id], 0);
      check("rst_done", done_a[id], 0);
      check("rst_no_answer", na_a[id], 0);
      check("rst_rd_col", rdcol_a[id], 0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int j = 0; j < 6; j++) apply_vec(j);

    // asynchronous reset in the middle of an N=8 search, then a clean re-run
    latmode[0] = 0;
    @(negedge clk);
    start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    repeat (100) @(negedge clk);
    check("mid_busy", busy_a[0], 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_req", req_a[0], 0);
    check("arst_busy", busy_a[0], 0);
    check("arst_valid", ov_a[0], 0);
    check("arst_out", out_a[0], 0);
    check("arst_row", row_a[0], 0);
    check("arst_done", done_a[0], 0);
    check("arst_no_answer", na_a[0], 0);
    check("arst_rd_col", rdcol_a[0], 0);
    @(negedge clk);
    #1 rst = 1'b0;
    apply_vec(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/queen_seq_ctrl.md
Name: queen_seq_ctrl

Overview:
Backtracking sequencer for the N-queen solver datapath. It owns the placement board, one column per row, and walks rows and columns. Each candidate placement goes to an external conflict-check unit over a req/ack handshake, and the unit reads earlier placements through a read port. When a full board is found, the block streams it out row by row as one-hot columns, then raises done, plus no_answer if the search space is exhausted.

Parameters:
N, 8, board size (rows = columns = N), legal range 2..16
CW, 3, row/column index width, equal to clog2(N)

Ports:
clk  in  1  clock; everything samples on the rising edge
rst  in  1  reset, asynchronous and active-high
start  in  1  begin a solve; sampled only in IDLE or FIN
chk_req  out  1  check request; high for the whole CHECK state
chk_row  out  CW  candidate row r, valid while chk_req is high
chk_col  out  CW  candidate column c, valid while chk_req is high
chk_ack  in  1  single-cycle pulse: check complete
chk_safe  in  1  qualified by chk_ack; 1 means no conflict with rows 0..r-1
brd_rd_row  in  CW  board read address from the checker
brd_rd_col  out  CW  combinational board[brd_rd_row]
busy  out  1  high from the cycle after start is accepted until FIN
out_valid  out  1  high during EMIT
out_row  out  CW  row being emitted
out  out  N  one-hot column of out_row, with out[board[out_row]] = 1
done  out  1  high in FIN, held until the next start or reset
no_answer  out  1  high in FIN when no solution exists, held with done

Behaviour:
- Reset (async, any state): state=IDLE, r=c=0, board all 0; every output 0 except brd_rd_col, which reads board, so 0.
- States: IDLE, CHECK, GAP, BACK, EMIT, FIN.
- IDLE / FIN + start → r=0, c=0, done=0, no_answer=0 → CHECK. start in any other state is ignored.
- CHECK:
  - chk_req=1, chk_row=r, chk_col=c. The block stays in CHECK until a rising edge samples chk_ack=1. An ack in the first CHECK cycle (zero-wait) is legal.
  - On the ack edge with chk_safe=1: board[r]←c. If r==N-1 → EMIT with k=0. Otherwise r←r+1, c←0 → GAP.
  - On the ack edge with chk_safe=0: if c<N-1 then c←c+1 → GAP, else → BACK.
- GAP: exactly 1 cycle with chk_req=0, then → CHECK. This guarantees req is low between consecutive requests.
- BACK:
  - If r==0 → FIN with no_answer=1.
  - Otherwise r←r-1. If board[r-1]<N-1 then c←board[r-1]+1 → GAP. Otherwise stay in BACK, one row per cycle.
- Board rows ≥ r hold stale values; the checker reads only rows < chk_row. brd_rd_col is purely combinational from board.
- EMIT:
  - k counts 0..N-1, one row per cycle: out_valid=1, out_row=k, out=onehot(board[k]).
  - After k=N-1 → FIN with no_answer=0.
  - out=0 and out_row=0 whenever out_valid=0.
- FIN: done=1, busy=0, board retained (readable via brd_rd_*).
- Search order is deterministic (lexicographic), so the first solution is fixed. For N=8 it is columns 0,4,7,5,2,6,1,3; for N=4 it is 1,3,0,2. N=2 and N=3 → no_answer.
- chk_ack outside CHECK is ignored. The c and r increments never exceed N-1 by construction; no wrap is allowed.

Test Plan:
1. N=8, zero-wait behavioural checker (ack in the same cycle as req): reset, pulse start for 1 cycle → 8 EMIT cycles with out = 0x01,0x10,0x80,0x20,0x04,0x40,0x02,0x08 on rows 0..7, then done=1, no_answer=0, busy=0.
2. N=4, checker acks 5 cycles after req rises → chk_req holds with stable chk_row/chk_col until ack; emitted out = 0b0010,0b1000,0b0001,0b0100; every req is separated by at least 1 low cycle.
3. N=3 → never enters EMIT, out_valid stays 0; done=1 and no_answer=1 in the same cycle; BACK is reached from r=0.
4. Mid-search, assert rst asynchronously (off the clock edge) → all outputs 0 immediately. Then start → identical result to scenario 1.
5. start pulsed while busy → ignored, result unchanged. start in FIN → done/no_answer clear on the next edge and the solve re-runs.
6. Scoreboard every chk_safe=1 ack against the bench checker: board read back via brd_rd_row during CHECK matches all prior placements. Total CHECK count for N=8 equals the reference-model count of 876.
